// File: rtl/gf16_inv_if.sv
// gf16_inv_if: operand/result handshake bundle for the GF(2^4) inverter.
interface gf16_inv_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_par;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_err;
  modport master (
    output in_valid, in_data, in_par, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );
  modport slave (
    input  in_valid, in_data, in_par, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/gf16_inv_seq.sv
// gf16_inv_seq: sequential GF(2^4) inverse (a^14) by three square-and-multiply steps, mod x^4+x+1.
// Optional input parity check enabled by defining GF16_INV_PARITY_EN.
module gf16_inv_seq (
  input logic      clk,
  input logic      rst,
  gf16_inv_if.slave bus
);
`ifdef GF16_INV_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, SQ1, SQ2, SQ3, HOLD} state_t;
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction
  state_t     state_q, state_d;
  logic [3:0] s_q, s_d, acc_q, acc_d, sq;
  logic       err_q, err_d;
  assign sq = gf_mul(s_q, s_q);
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = SQ1;
        s_d     = bus.in_data;
        acc_d   = 4'h1;
        err_d   = PAR_EN & (bus.in_par ^ (^bus.in_data));
      end
      SQ1, SQ2, SQ3: begin
        state_d = state_q == SQ1 ? SQ2 : state_q == SQ2 ? SQ3 : HOLD;
        s_d     = sq;
        acc_d   = gf_mul(acc_q, sq);
      end
      HOLD: state_d = bus.out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == HOLD;
  assign bus.out_data  = bus.out_valid ? acc_q : 4'h0;
  assign bus.out_err   = bus.out_valid & err_q;
endmodule

// File: tb/tb_gf16_inv_seq.sv
// tb_gf16_inv_seq: vector table plus scoreboard bench for gf16_inv_seq.
module tb_gf16_inv_seq;
`ifdef GF16_INV_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  typedef struct {logic [3:0] d; logic p; logic [3:0] ed; logic ee;} vec_t;
  typedef struct {logic [3:0] ed; logic ee; int t;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gf16_inv_if bus();
  gf16_inv_seq dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t sb[$];
  vec_t vec[16];
  int checks = 0, errors = 0, cyc = 0, last_acc = -1;
  bit b2b = 1'b0, ov_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst) ov_prev = 1'b0;
    else begin
      if (!bus.out_valid) chk("idle_data_zero", int'(bus.out_data), 0);
      if (bus.out_valid) chk("no_ready_in_hold", int'(bus.in_ready), 0);
      if (bus.out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("latency", cyc - sb[0].t, 4);
      end
      if (bus.in_valid && bus.in_ready) begin
        if (b2b && last_acc >= 0) chk("accept_gap", cyc - last_acc, 5);
        last_acc = cyc;
      end
      if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", int'(bus.out_data), int'(e.ed));
        chk("out_err", int'(bus.out_err), int'(e.ee));
      end
      ov_prev = bus.out_valid;
    end
  end
  task automatic send(input logic [3:0] d, input logic p, input logic [3:0] ed, input logic ee,
                      input bit push, input bit keep);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_par   = p;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", int'(bus.in_ready), 1);
    if (bus.in_ready && push) sb.push_back('{ed, ee, cyc});
    @(posedge clk);
    #1;
    if (!keep) bus.in_valid = 1'b0;
    bus.in_data = 4'($urandom);
    bus.in_par  = 1'($urandom);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] inv_tab [16];
    int n, cnt;
    inv_tab = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};
    for (int i = 0; i < 16; i++) begin
      logic [3:0] d;
      logic flip;
      d = 4'(i);
      flip = (i % 5 == 3);
      vec[i] = '{d, (^d) ^ flip, inv_tab[i], PEN & flip};
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.in_par    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    send(4'h2, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 16; i++) send(vec[i].d, vec[i].p, vec[i].ed, vec[i].ee, 1'b1, 1'b0);
    drain();
    bus.out_ready = 1'b0;
    send(4'h3, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 10);
    chk("hold_reached", int'(bus.out_valid), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h7;
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_data", int'(bus.out_data), 4'hE);
      chk("hold_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    send(4'h5, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("rst_discard", cnt, 0);
    @(posedge clk);
    #1;
    send(4'h8, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
    drain();
    send(4'h6, 1'b1, 4'h7, PEN, 1'b1, 1'b0);
    drain();
    b2b = 1'b1;
    last_acc = -1;
    for (int i = 10; i < 14; i++) send(vec[i].d, vec[i].p, vec[i].ed, vec[i].ee, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    drain();
    b2b = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
